// File: rtl/video_control_sequencer_if.sv
// video_control_sequencer_if: command push bus and formatter control outputs
interface video_control_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [7:0]  control_op;
    logic [31:0] control_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, control_op, control_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, control_op, control_data
    );
endinterface

// File: rtl/video_control_sequencer.sv
// video_control_sequencer: queues formatter commands and plays each out as setup/hold/gap (VIDEO_CTRL_VBLANK_DEFER_EN defers frame-geometry ops to vblank)
module video_control_sequencer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                        m_axis_vid_aclk,
    input  logic                        areset,
    input  logic                        flush,
    input  logic                        control_vblank,
    video_control_sequencer_if.slave    bus,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] DEPTH     = LW'(FIFO_DEPTH);
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] HOLD     = 3'd2;
    localparam logic [2:0] GAP      = 3'd3;

    logic [39:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          rdy, full, empty, push, pop, defer;
    logic [2:0]    state;
    logic [3:0]    cnt;
    logic [7:0]    op_r, head_op;
    logic [31:0]   data_r;

    assign full          = fifo_level == DEPTH;
    assign empty         = fifo_level == '0;
    assign bus.cmd_ready = rdy && !full;
    assign push          = bus.cmd_valid && bus.cmd_ready && !flush;
    assign pop           = state == IDLE && !empty && !flush;
    assign head_op       = mem[rptr][39:32];
    assign busy          = state != IDLE || !empty;

`ifdef VIDEO_CTRL_VBLANK_DEFER_EN
    localparam logic [2:0] WAIT_VBL = 3'd4;
    logic [2:0] vs;
    logic       vbl_event;

    // two synchronizer flops plus one history flop for rising-edge detection
    always_ff @(posedge m_axis_vid_aclk or posedge areset)
        if (areset) vs <= '0;
        else        vs <= {vs[1:0], control_vblank};

    assign vbl_event = vs[1] && !vs[2];
    assign defer     = head_op inside {8'd1, 8'd2, 8'd4, 8'd13};
`else
    logic unused_vblank;
    assign unused_vblank = control_vblank;
    assign defer         = 1'b0;
`endif

    // FIFO storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge m_axis_vid_aclk)
        if (push) mem[wptr] <= {bus.cmd_op, bus.cmd_data};

    // pointers and level; rdy holds cmd_ready low until the first edge after reset
    always_ff @(posedge m_axis_vid_aclk or posedge areset)
        if (areset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            rdy        <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (flush) begin
                wptr       <= '0;
                rptr       <= '0;
                fifo_level <= '0;
            end else begin
                wptr       <= wptr + AW'(push);
                rptr       <= rptr + AW'(pop);
                fifo_level <= fifo_level + LW'(push) - LW'(pop);
            end
        end

    // sequencing FSM; control_op is registered so it lags the HOLD state by one cycle
    always_ff @(posedge m_axis_vid_aclk or posedge areset)
        if (areset) begin
            state          <= IDLE;
            cnt            <= '0;
            op_r           <= '0;
            data_r         <= '0;
            bus.control_op   <= '0;
            bus.control_data <= '0;
        end else begin
            bus.control_op <= (state == HOLD && !flush) ? op_r : 8'h00;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE:
                        if (pop && head_op != 8'h00) begin
                            op_r   <= head_op;
                            data_r <= mem[rptr][31:0];
`ifdef VIDEO_CTRL_VBLANK_DEFER_EN
                            state  <= defer ? WAIT_VBL : SETUP;
`else
                            state  <= SETUP;
`endif
                        end
`ifdef VIDEO_CTRL_VBLANK_DEFER_EN
                    WAIT_VBL:
                        if (vbl_event) state <= SETUP;
`endif
                    SETUP: begin
                        bus.control_data <= data_r;
                        state            <= HOLD;
                        cnt              <= '0;
                    end
                    HOLD: begin
                        cnt   <= cnt == HOLD_LAST ? 4'd0 : cnt + 4'd1;
                        state <= cnt == HOLD_LAST ? GAP : HOLD;
                    end
                    GAP: begin
                        cnt   <= cnt == GAP_LAST ? 4'd0 : cnt + 4'd1;
                        state <= cnt == GAP_LAST ? IDLE : GAP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

    logic unused_defer;
    assign unused_defer = defer;
endmodule

// File: tb/tb_video_control_sequencer.sv
// tb_video_control_sequencer: directed vectors with hand-computed expectations
module tb_video_control_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       vblank = 1'b0;
    logic       busy;
    logic [4:0] level;

    video_control_sequencer_if bus();

    video_control_sequencer #(
        .FIFO_DEPTH(16), .HOLD_CYCLES(4), .GAP_CYCLES(2)
    ) dut (
        .m_axis_vid_aclk(clk),
        .areset(rst),
        .flush(flush),
        .control_vblank(vblank),
        .bus(bus),
        .busy(busy),
        .fifo_level(level)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          nz2nz = 0;
    logic [7:0]  prev_op = 8'h00;
    logic [39:0] got_q[$];
    logic [39:0] exp_q[$];

    // record each new output op with its operand and catch direct nonzero-to-nonzero changes
    always @(negedge clk) begin
        if (prev_op != 8'h00 && bus.control_op != 8'h00 && bus.control_op != prev_op) nz2nz <= nz2nz + 1;
        if (prev_op == 8'h00 && bus.control_op != 8'h00) got_q.push_back({bus.control_op, bus.control_data});
        prev_op <= bus.control_op;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] op, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        tick;
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int base, nzb, w;
        logic seen_full;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 8'h00;
        bus.cmd_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op", bus.control_op, 0);
        check("rst_data", bus.control_data, 0);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        rst = 1'b0;
        tick;
        check("ready_after_release", bus.cmd_ready, 1);

        // single command: data after k+2, op for 4 cycles, 2 gap cycles
        push(8'h03, 32'h05FF0000);
        check("t1_level", level, 1);
        tick;
        check("t1_data_k1", bus.control_data, 0);
        tick;
        check("t1_data_k2", bus.control_data, 32'h05FF0000);
        check("t1_op_k2", bus.control_op, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t1_hold", bus.control_op, 8'h03);
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            check("t1_gap", bus.control_op, 0);
        end
        check("t1_busy_end", busy, 0);

        // no-op followed by op 15: no-op is silent, op 15 at its own normal latency
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 8'h00;
        bus.cmd_data  = 32'hDEADBEEF;
        tick;
        bus.cmd_op    = 8'h0F;
        bus.cmd_data  = 32'h00FF00FF;
        tick;
        bus.cmd_valid = 1'b0;
        check("t2_op_k1", bus.control_op, 0);
        tick;
        check("t2_op_k2", bus.control_op, 0);
        check("t2_data_kept", bus.control_data, 32'h05FF0000);
        tick;
        check("t2_data_k3", bus.control_data, 32'h00FF00FF);
        check("t2_op_k3", bus.control_op, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t2_hold", bus.control_op, 8'h0F);
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            check("t2_gap", bus.control_op, 0);
        end
        check("t2_busy_end", busy, 0);

        // burst while the first command holds: fill to 16, everything emitted in order
        base = got_q.size();
        nzb  = nz2nz;
        seen_full = 1'b0;
        exp_q.delete();
        push(8'h40, 32'h10000000);
        exp_q.push_back({8'h40, 32'h10000000});
        repeat (3) tick;
        for (int i = 1; i <= 20; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 8'(8'h40 + i);
            bus.cmd_data  = 32'h10000000 + 32'(i);
            w = 0;
            while (!bus.cmd_ready && w < 40) begin
                if (!seen_full) begin
                    seen_full = 1'b1;
                    check("full_level", level, 16);
                end
                tick;
                w++;
            end
            if (w == 40) check("burst_timeout", 0, 1);
            tick;
            exp_q.push_back({8'(8'h40 + i), 32'h10000000 + 32'(i)});
        end
        bus.cmd_valid = 1'b0;
        check("saw_full", seen_full, 1);
        w = 0;
        while (busy && w < 400) begin
            tick;
            w++;
        end
        check("burst_drain", busy, 0);
        check("burst_count", got_q.size() - base, 21);
        for (int i = 0; i < 21 && base + i < got_q.size(); i++)
            check("burst_order", got_q[base + i], exp_q[i]);
        check("burst_nz2nz", nz2nz - nzb, 0);

        // flush during HOLD with five queued; a push alongside flush is dropped
        push(8'h50, 32'hA0A0A0A0);
        for (int i = 1; i <= 5; i++) push(8'(8'h50 + i), 32'(i));
        check("fl_level_before", level, 5);
        check("fl_op_before", bus.control_op, 8'h50);
        flush = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 8'h77;
        bus.cmd_data  = 32'h77777777;
        tick;
        flush = 1'b0;
        bus.cmd_valid = 1'b0;
        check("fl_op", bus.control_op, 0);
        check("fl_level", level, 0);
        check("fl_busy", busy, 0);
        check("fl_data_kept", bus.control_data, 32'hA0A0A0A0);
        repeat (3) tick;
        check("fl_op_later", bus.control_op, 0);

        // asynchronous reset in the middle of HOLD
        push(8'h60, 32'h12345678);
        repeat (3) tick;
        check("ar_op_before", bus.control_op, 8'h60);
        #2;
        rst = 1'b1;
        #1;
        check("ar_op", bus.control_op, 0);
        check("ar_data", bus.control_data, 0);
        check("ar_ready", bus.cmd_ready, 0);
        check("ar_level", level, 0);
        check("ar_busy", busy, 0);
        tick;
        rst = 1'b0;
        tick;
        check("ar_ready_release", bus.cmd_ready, 1);
        check("ar_op_release", bus.control_op, 0);

`ifdef VIDEO_CTRL_VBLANK_DEFER_EN
        // deferred op waits for a synchronized vblank rising edge
        w = 0;
        push(8'h02, 32'h02400280);
        for (int i = 0; i < 100; i++) begin
            tick;
            if (bus.control_op != 8'h00) w++;
        end
        check("vbl_wait_quiet", w, 0);
        vblank = 1'b1;
        w = 0;
        while (bus.control_op != 8'h02 && w < 6) begin
            tick;
            w++;
        end
        check("vbl_op", bus.control_op, 8'h02);
        check("vbl_data", bus.control_data, 32'h02400280);
        vblank = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
